// File: rtl/reg_dump_ctrl_if.sv
// Beat stream leaving reg_dump_ctrl: one (register index, register value) pair
// per valid/ready handshake.
interface reg_dump_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_idx, output out_data, input out_ready);
    modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/reg_dump_ctrl.sv
// Debug register-file dumper: walks indices through an async read port and streams
// (index, data) beats, ending with a done pulse. REG_DUMP_SKIP_ZERO_EN suppresses zero-valued registers.
module reg_dump_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_W-1:0]    rf_raddr,
    input  logic [DATA_W-1:0]    rf_rdata,
    reg_dump_ctrl_if.master      dump,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_SEND, ST_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              skip_zero;

`ifdef REG_DUMP_SKIP_ZERO_EN
    assign skip_zero = (rf_rdata == '0);
`else
    assign skip_zero = 1'b0;
`endif

    // The read port is only claimed during READ; index 0 elsewhere keeps it idle-safe.
    assign rf_raddr = (state == ST_READ) ? idx : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            dump.out_valid <= 1'b0;
            dump.out_idx   <= '0;
            dump.out_data  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_READ;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (skip_zero) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end else begin
                        // Capture here so the beat stays frozen even if the register file changes.
                        dump.out_data  <= rf_rdata;
                        dump.out_idx   <= idx;
                        dump.out_valid <= 1'b1;
                        state          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (dump.out_ready) begin
                        dump.out_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Randomized bench for reg_dump_ctrl against a beat-list reference model built
// from a register-file snapshot taken when a dump is accepted.
module tb_reg_dump_ctrl;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    localparam int RDY_ALWAYS = 0, RDY_RAND = 1, RDY_STALL3 = 2, RDY_HOLD7 = 3;
    localparam int ST_OFF = 0, ST_ONESHOT = 1, ST_HOLD = 2, ST_RAND = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rf [N];

    reg_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dump ();

    reg_dump_ctrl #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .dump     (dump),
        .busy     (busy),
        .done     (done)
    );

    assign rf_rdata = rf[rf_raddr];

    always #5 clk = ~clk;

    // Reference model: list of expected beats, each with the number of read
    // cycles (lead) spent before it is presented.
    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            lead;
    } beat_t;

    beat_t q[$];
    int    tail;
    int    wait_n;
    bit    mdl_busy;

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0;
    int dut_beats = 0, dut_done = 0, dut_lat = 0;
    int ready_mode = RDY_ALWAYS, start_mode = ST_OFF;
    int stall_left = 0;
    bit at7 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_val();
        return ($urandom_range(0, 9) < 3) ? '0 : DW'($urandom);
    endfunction

    function automatic void build_model();
        int zr = 0;
        q.delete();
        for (int i = 0; i < N; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
            if (rf[i] == '0) begin
                zr++;
                continue;
            end
`endif
            q.push_back('{idx: i, data: rf[i], lead: zr + 1});
            zr = 0;
        end
        tail = zr;
    endfunction

    // Cycle count from the start-sampling edge to the done cycle, with ready always high.
    function automatic int spec_latency();
        int c = 1;
        for (int i = 0; i < N; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
            c += (rf[i] == '0) ? 1 : 2;
`else
            c += 2;
`endif
        end
        return c;
    endfunction

    function automatic int spec_beats();
        int c = 0;
        for (int i = 0; i < N; i++) begin
`ifdef REG_DUMP_SKIP_ZERO_EN
            if (rf[i] != '0) c++;
`else
            c++;
`endif
        end
        return c;
    endfunction

    task automatic tick();
        bit exp_valid, exp_done, rdy, st;
        int exp_raddr;
        @(negedge clk);
        cyc++;
        if (mdl_busy && wait_n > 0) wait_n--;
        exp_valid = mdl_busy && wait_n == 0 && q.size() > 0;
        exp_done  = mdl_busy && wait_n == 0 && q.size() == 0;
        exp_raddr = 0;
        if (mdl_busy && wait_n > 0)
            exp_raddr = (q.size() > 0) ? q[0].idx - wait_n + 1 : N - wait_n;

        check_eq("busy", busy, mdl_busy);
        check_eq("out_valid", dump.out_valid, exp_valid);
        check_eq("done", done, exp_done);
        check_eq("rf_raddr", rf_raddr, exp_raddr);
        if (exp_valid) begin
            check_eq("out_idx", dump.out_idx, q[0].idx);
            check_eq("out_data", dump.out_data, q[0].data);
            if (q[0].idx == 7) at7 = 1;
        end
        if (done) begin
            dut_done++;
            dut_lat = cyc - start_cyc;
        end

        case (ready_mode)
            RDY_RAND:   rdy = ($urandom_range(0, 3) != 0);
            RDY_STALL3: begin
                rdy = 1;
                if (exp_valid && q[0].idx == 3 && stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end
            end
            RDY_HOLD7:  rdy = !(exp_valid && q[0].idx == 7);
            default:    rdy = 1;
        endcase
        case (start_mode)
            ST_ONESHOT: begin st = 1; start_mode = ST_OFF; end
            ST_HOLD:    st = 1;
            ST_RAND:    st = ($urandom_range(0, 15) == 0);
            default:    st = 0;
        endcase

        // Held beats were captured already, so rewriting their register must not show.
        if (exp_valid && !rdy) rf[q[0].idx] = DW'($urandom);
        if (!mdl_busy && ready_mode == RDY_RAND) rf[$urandom_range(0, N - 1)] = rnd_val();

        start          = st;
        dump.out_ready = rdy;
        if (dump.out_valid && rdy) dut_beats++;

        if (exp_valid && rdy) begin
            void'(q.pop_front());
            wait_n = ((q.size() > 0) ? q[0].lead : tail) + 1;
        end
        if (exp_done) begin
            mdl_busy = 0;
        end else if (!mdl_busy && st) begin
            build_model();
            mdl_busy  = 1;
            wait_n    = ((q.size() > 0) ? q[0].lead : tail) + 1;
            start_cyc = cyc;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset          = 1'b0;
        start          = 1'b0;
        dump.out_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", dump.out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_idx", dump.out_idx, 0);
        check_eq("rst_data", dump.out_data, 0);
        check_eq("rst_raddr", rf_raddr, 0);
        reset    = 1'b1;
        q.delete();
        mdl_busy = 0;
        wait_n   = 0;
    endtask

    task automatic clear_counts();
        dut_beats = 0;
        dut_done  = 0;
        dut_lat   = 0;
    endtask

    task automatic run_until_done(input int target, input int bound, input string tag);
        int n = 0;
        while (dut_done < target && n < bound) begin
            tick();
            n++;
        end
        check_eq({tag, "_reached_done"}, dut_done >= target, 1);
    endtask

    task automatic run_until_idle(input int bound, input string tag);
        int n = 0;
        while (mdl_busy && n < bound) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, mdl_busy, 0);
        tick();
    endtask

    initial begin
        int exp_lat, exp_beats;
        reset          = 1'b0;
        start          = 1'b0;
        dump.out_ready = 1'b0;
        for (int i = 0; i < N; i++) rf[i] = '0;
        mdl_busy = 0;
        wait_n   = 0;
        tail     = 0;

        do_reset(3);
        repeat (3) tick();

        // Full dump, ready always high.
        for (int i = 0; i < N; i++) rf[i] = (i == 0) ? '0 : DW'(i * 4 + 'h100);
        rf[2]      = 'h2ffc;
        exp_lat    = spec_latency();
        exp_beats  = spec_beats();
        clear_counts();
        ready_mode = RDY_ALWAYS;
        start_mode = ST_ONESHOT;
        run_until_done(1, 200, "full");
        check_eq("full_latency", dut_lat, exp_lat);
        check_eq("full_beats", dut_beats, exp_beats);
        repeat (4) tick();
        check_eq("full_done_once", dut_done, 1);

        // Backpressure at index 3 for five cycles with rf[3] rewritten meanwhile.
        clear_counts();
        exp_beats  = spec_beats();
        stall_left = 5;
        ready_mode = RDY_STALL3;
        start_mode = ST_ONESHOT;
        run_until_done(1, 250, "stall");
        check_eq("stall_used", stall_left, 0);
        check_eq("stall_beats", dut_beats, exp_beats);
        run_until_idle(10, "stall");

        // start held high: ignored while busy and on done, restarts from IDLE.
        clear_counts();
        ready_mode = RDY_RAND;
        start_mode = ST_HOLD;
        run_until_done(2, 800, "hold");
        start_mode = ST_OFF;
        run_until_idle(400, "hold");
        check_eq("hold_dumps", dut_done, 2);

        // Reset while a beat for index 7 is held.
        for (int i = 0; i < N; i++) rf[i] = DW'(i + 1);
        at7        = 0;
        ready_mode = RDY_HOLD7;
        start_mode = ST_ONESHOT;
        for (int n = 0; n < 100 && !at7; n++) tick();
        check_eq("reach_idx7", at7, 1);
        do_reset(1);
        clear_counts();
        ready_mode = RDY_ALWAYS;
        repeat (10) tick();
        check_eq("post_rst_beats", dut_beats, 0);
        check_eq("post_rst_done", dut_done, 0);

        // Only rf[2] nonzero.
        for (int i = 0; i < N; i++) rf[i] = '0;
        rf[2] = 'h2ffc;
        clear_counts();
        exp_lat    = spec_latency();
        start_mode = ST_ONESHOT;
        run_until_done(1, 200, "sparse");
`ifdef REG_DUMP_SKIP_ZERO_EN
        check_eq("sparse_beats", dut_beats, 1);
`else
        check_eq("sparse_beats", dut_beats, N);
`endif
        check_eq("sparse_latency", dut_lat, exp_lat);
        run_until_idle(10, "sparse");

        // Random register contents, ready and start.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) rf[i] = rnd_val();
            if (r == 1) rf[N - 1] = '0;
            ready_mode = RDY_RAND;
            start_mode = ST_RAND;
            repeat (250) tick();
            start_mode = ST_OFF;
            run_until_idle(400, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
- Debug reader for the CPU register file. On `start` (tied to the halt indication), it walks register indices through one asynchronous register-file read port.
- Each read value is captured and streamed out over a valid/ready interface as (index, data) beats, ending with a `done` pulse.
- Sits beside the register file. Owns its read port only while `busy`; the datapath owns it otherwise.

Parameters:
- NUM_REGS, 32, number of registers walked, indices 0..NUM_REGS-1
- ADDR_W, 5, width of the register index
- DATA_W, 32, register data width

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-low; reset==0 at posedge clears all state
- start  input  1  begin a dump; sampled only in IDLE
- rf_raddr  output  ADDR_W  register index driven to the register-file read port
- rf_rdata  input  DATA_W  asynchronous read data for rf_raddr, valid the same cycle
- out_valid  output  1  beat available
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready at posedge
- out_idx  output  ADDR_W  register index of the current beat
- out_data  output  DATA_W  register value of the current beat
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, idx=0.
  - out_valid=0, out_idx=0, out_data=0, done=0, busy=0, rf_raddr=0.
  - Reset takes effect in any state, including mid-dump. Any held beat is discarded; no done pulse follows.
- States and transitions:
  - IDLE: rf_raddr=0.
    - start=1 → READ with idx=0.
    - start=0 → stay.
  - READ: rf_raddr=idx. At posedge, capture out_data<=rf_rdata and out_idx<=idx, set out_valid<=1, → SEND. Occupies exactly one cycle.
  - SEND: out_valid=1. out_idx and out_data are held stable until accepted, even if the register file changes.
    - Handshake (out_ready=1) with idx==NUM_REGS-1 → DONE, out_valid<=0.
    - Handshake with any other idx → idx<=idx+1, → READ, out_valid<=0.
    - No handshake → stay.
  - DONE: done=1 for exactly one cycle, then → IDLE. idx<=0.
- Handshake rules:
  - out_valid never drops without a handshake, except on reset.
  - out_ready is ignored when out_valid=0.
- Timing:
  - Minimum 2 cycles per beat (READ + SEND with out_ready held high).
  - Full dump: 2*NUM_REGS cycles from the start-sampled posedge, plus one DONE cycle.
- start while busy: ignored. No restart or queueing.
- start=1 on the DONE cycle: ignored. start held high continuously → a new dump begins on the cycle after returning to IDLE.
- idx arithmetic: ADDR_W bits. The last-index compare uses NUM_REGS-1, so there is no wrap past the final register.
- rf_raddr is combinational from state/idx. It is 0 outside READ so the read port is idle-safe.

Optional Feature:
- Macro: REG_DUMP_SKIP_ZERO_EN
- Defined:
  - In READ, if rf_rdata==0 and idx!=NUM_REGS-1, no beat is produced; idx<=idx+1 and the state stays READ.
  - If rf_rdata==0 and idx==NUM_REGS-1, go directly to DONE with no beat.
  - out_idx still reports the true register index of each emitted beat.
- Undefined: every register produces a beat, zero-valued or not.

Test Plan:
- Reset mid-SEND: pull reset low while out_valid=1 at idx=7 → next cycle out_valid=0, busy=0, done=0, state IDLE; no further beats.
- Full dump, out_ready=1 constantly, rf[i]=i*4+0x100 for i≠0, rf[2]=0x2ffc → 32 beats in order, out_idx 0..31, out_data matches (idx0=0, idx2=0x2ffc, idx31=0x17C). done pulses once, at cycle 65 after start.
- Backpressure: out_ready=0 for 5 cycles at idx=3 → out_valid stays 1, out_idx=3 and out_data stable for all 5 cycles, even with rf[3] rewritten meanwhile. Released → idx 4 follows.
- start=1 while busy and on the DONE cycle → no second dump. start held high continuously → second dump begins the cycle after IDLE, idx restarts at 0.
- REG_DUMP_SKIP_ZERO_EN defined, after reset (only rf[2]=0x2ffc nonzero) → exactly one beat (idx=2, data=0x2ffc), then done. Undefined → 32 beats.
